// File: rtl/survival_timer_pkg.sv
// survival_timer_pkg: state encoding, digit limits and digit-advance helper for survival_timer
package survival_timer_pkg;
  typedef enum logic [1:0] {RUN, CARRY, STOPPED} state_t;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] DIGIT_CARRY = 4'd10;
  // Out-of-range digits (11-15) fall back to 0 on the next tick
  function automatic logic [3:0] next_digit(input logic [3:0] d);
    return d == DIGIT_MAX ? DIGIT_CARRY : d > DIGIT_MAX ? 4'd0 : d + 4'd1;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts 0..TICK_DIV-1 while enabled; wrap flags the last count of each period
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic wrap
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] count;
  assign wrap = enable && count == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= wrap ? '0 : count + 1'b1;
endmodule

// File: rtl/survival_timer.sv
// survival_timer: one-second BCD ones digit with carry-hold encoding, frozen on collision.
// SURVIVAL_TIMER_PAUSE_EN adds a pause input that holds counting while in RUN.
module survival_timer
  import survival_timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       collided,
  input  logic       key_press,
`ifdef SURVIVAL_TIMER_PAUSE_EN
  input  logic       pause,
`endif
  output logic [3:0] binary_time,
  output logic       carry,
  output logic       tick,
  output logic       running
);
  state_t state, state_n;
  logic [3:0] digit_n;
  logic tick_n, wrap, enable, hold;
`ifdef SURVIVAL_TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif
  // CARRY always counts so the carry cycle never stretches the tick period
  assign enable = state == CARRY || (state == RUN && !collided && !hold);
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk(CLOCK_50),
    .rst_n(resetn),
    .enable(enable),
    .clear(key_press),
    .wrap(wrap)
  );
  always_comb begin
    state_n = state;
    digit_n = binary_time;
    tick_n = 1'b0;
    if (key_press) begin
      state_n = RUN;
      digit_n = '0;
    end else if (state == CARRY) begin
      digit_n = '0;
      state_n = collided ? STOPPED : RUN;
    end else if (state == RUN && collided) begin
      state_n = STOPPED;
    end else if (wrap) begin
      tick_n = 1'b1;
      digit_n = next_digit(binary_time);
      state_n = binary_time == DIGIT_MAX ? CARRY : RUN;
    end
  end
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      state <= RUN;
      binary_time <= '0;
      tick <= 1'b0;
    end else begin
      state <= state_n;
      binary_time <= digit_n;
      tick <= tick_n;
    end
  assign carry = state == CARRY;
  assign running = state != STOPPED;
endmodule
